// File: rtl/ledmem_arbiter.sv
// Write-port owner for the 256x24 LED display RAM: round-robin arbiter for two
// requesters plus a bulk-clear sequencer, optionally gated to the serialiser's reset gap.
module ledmem_arbiter #(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       DATA_W      = 24,
  parameter int unsigned       PIXELS      = 256,
  parameter bit                SYNC_WRITES = 1'b1,
  parameter logic [DATA_W-1:0] CLR_VALUE   = '0
) (
  input  logic              CLK50,
  input  logic              RESET,
  input  logic [2:0]        SER_STATE,
  input  logic              REQ0,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] DATA0,
  output logic              GNT0,
  input  logic              REQ1,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] DATA1,
  output logic              GNT1,
  input  logic              CLR_START,
  output logic              CLR_DONE,
  output logic [ADDR_W-1:0] MEM_A,
  output logic [DATA_W-1:0] MEM_D,
  output logic              MEM_WE,
  output logic              BUSY,
  output logic              ADDR_ERR
);

  localparam int unsigned      CNT_W     = ADDR_W + 1;
  localparam logic [2:0]       SER_RESET = 3'd1;
  localparam logic [CNT_W-1:0] PIX_LIM   = CNT_W'(PIXELS);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ptr_q, ptr_d;
  logic              cool0_q, cool0_d;
  logic              cool1_q, cool1_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [DATA_W-1:0] mem_d_q, mem_d_d;
  logic              we_q, we_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              win_open;
  logic              elig0, elig1, pick1, sel_oob;
  logic [ADDR_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_d;

  // Arbitration winner; ptr_q names the requester favoured on a tie.
  always_comb begin : arb_select
    win_open = (SYNC_WRITES == 1'b0) || (SER_STATE == SER_RESET);
    elig0    = REQ0 && !cool0_q;
    elig1    = REQ1 && !cool1_q;
    pick1    = elig1 && (!elig0 || ptr_q);
    sel_a    = pick1 ? ADDR1 : ADDR0;
    sel_d    = pick1 ? DATA1 : DATA0;
    sel_oob  = ({1'b0, sel_a} >= PIX_LIM);
  end

  always_comb begin : next_state
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    cool0_d = 1'b0;
    cool1_d = 1'b0;
    mem_a_d = mem_a_q;
    mem_d_d = mem_d_q;
    we_d    = 1'b0;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (CLR_START) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else if (win_open && (elig0 || elig1)) begin
          if (elig0 && elig1) ptr_d = !ptr_q;
          gnt0_d  = !pick1;
          gnt1_d  = pick1;
          cool0_d = !pick1;
          cool1_d = pick1;
          if (sel_oob) begin
            err_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            mem_a_d = sel_a;
            mem_d_d = sel_d;
          end
        end
      end
      S_CLEAR: begin
        // Counter past the last pixel: report completion the cycle after the final write.
        if (cnt_q == PIX_LIM) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (win_open) begin
          we_d    = 1'b1;
          mem_a_d = ADDR_W'(cnt_q);
          mem_d_d = CLR_VALUE;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CLK50) begin : regs
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      cool0_q <= 1'b0;
      cool1_q <= 1'b0;
      mem_a_q <= '0;
      mem_d_q <= '0;
      we_q    <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      cool0_q <= cool0_d;
      cool1_q <= cool1_d;
      mem_a_q <= mem_a_d;
      mem_d_q <= mem_d_d;
      we_q    <= we_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign MEM_A    = mem_a_q;
  assign MEM_D    = mem_d_q;
  assign MEM_WE   = we_q;
  assign GNT0     = gnt0_q;
  assign GNT1     = gnt1_q;
  assign BUSY     = busy_q;
  assign CLR_DONE = done_q;
  assign ADDR_ERR = err_q;

endmodule

// File: tb/tb_ledmem_arbiter.sv
// Scoreboard bench for ledmem_arbiter: directed stimulus pushes expected output
// events; a monitor pops and compares whenever the DUT shows grant/write/error/done.
module tb_ledmem_arbiter;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 24;
  localparam int unsigned PIX = 200;

  logic          CLK50 = 1'b0;
  logic          RESET;
  logic [2:0]    SER_STATE;
  logic          REQ0, REQ1, CLR_START;
  logic [AW-1:0] ADDR0, ADDR1;
  logic [DW-1:0] DATA0, DATA1;
  logic          GNT0, GNT1, CLR_DONE, MEM_WE, BUSY, ADDR_ERR;
  logic [AW-1:0] MEM_A;
  logic [DW-1:0] MEM_D;

  typedef struct {
    logic          g0, g1, we, err, done, busy;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            cyc;
  } ev_t;

  ev_t           sb_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            mon_en = 1'b0;
  bit            stop = 1'b0;
  logic [AW-1:0] last_a = '0;
  logic [DW-1:0] last_d = '0;

  ledmem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .PIXELS(PIX), .SYNC_WRITES(1'b1), .CLR_VALUE(24'h000000)
  ) dut (
    .CLK50(CLK50), .RESET(RESET), .SER_STATE(SER_STATE),
    .REQ0(REQ0), .ADDR0(ADDR0), .DATA0(DATA0), .GNT0(GNT0),
    .REQ1(REQ1), .ADDR1(ADDR1), .DATA1(DATA1), .GNT1(GNT1),
    .CLR_START(CLR_START), .CLR_DONE(CLR_DONE),
    .MEM_A(MEM_A), .MEM_D(MEM_D), .MEM_WE(MEM_WE),
    .BUSY(BUSY), .ADDR_ERR(ADDR_ERR)
  );

  always #10 CLK50 = ~CLK50;
  always @(posedge CLK50) cyc <= cyc + 1;

  // Expected event; a/d follow the last issued write when no write happens.
  function automatic void push(input logic g0, input logic g1, input logic we, input logic err,
                               input logic done, input logic busy, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input int c);
    ev_t e;
    if (we) begin
      last_a = a;
      last_d = d;
    end
    e.g0 = g0; e.g1 = g1; e.we = we; e.err = err; e.done = done; e.busy = busy;
    e.a = last_a; e.d = last_d; e.cyc = c;
    sb_q.push_back(e);
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  task automatic monitor();
    ev_t e;
    int  n = 0;
    forever begin
      @(negedge CLK50);
      if (mon_en && (GNT0 || GNT1 || MEM_WE || ADDR_ERR || CLR_DONE)) begin
        checks++;
        n++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event#%0d cyc=%0d: got g0=%b g1=%b we=%b err=%b done=%b a=%h d=%h want no event",
                   n, cyc, GNT0, GNT1, MEM_WE, ADDR_ERR, CLR_DONE, MEM_A, MEM_D);
        end else begin
          e = sb_q.pop_front();
          if ({GNT0, GNT1, MEM_WE, ADDR_ERR, CLR_DONE, BUSY, MEM_A, MEM_D} !==
              {e.g0, e.g1, e.we, e.err, e.done, e.busy, e.a, e.d} ||
              (e.cyc >= 0 && e.cyc != cyc)) begin
            errors++;
            $display("FAIL event#%0d: got g0=%b g1=%b we=%b err=%b done=%b busy=%b a=%h d=%h cyc=%0d want g0=%b g1=%b we=%b err=%b done=%b busy=%b a=%h d=%h cyc=%0d",
                     n, GNT0, GNT1, MEM_WE, ADDR_ERR, CLR_DONE, BUSY, MEM_A, MEM_D, cyc,
                     e.g0, e.g1, e.we, e.err, e.done, e.busy, e.a, e.d, e.cyc);
          end
        end
      end
    end
  endtask

  // Hold a request until granted, keep it one more cycle, then drop it.
  task automatic do_req(input bit k, input logic [AW-1:0] a, input logic [DW-1:0] d, input int bound);
    bit got = 1'b0;
    if (k) begin REQ1 = 1'b1; ADDR1 = a; DATA1 = d; end
    else   begin REQ0 = 1'b1; ADDR0 = a; DATA0 = d; end
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge CLK50);
      got = k ? GNT1 : GNT0;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL req%0d_grant_timeout: got no grant in %0d cycles want a grant", k, bound);
    end
    @(posedge CLK50); #1;
    if (k) REQ1 = 1'b0; else REQ0 = 1'b0;
  endtask

  task automatic drain(input string name, input int bound);
    for (int i = 0; i < bound && sb_q.size() != 0; i++) @(negedge CLK50);
    repeat (3) @(negedge CLK50);
    check(name, 64'(sb_q.size()), 64'(0));
    @(posedge CLK50); #1;
  endtask

  initial begin
    int  c;
    bit  hit;
    RESET = 1'b1; SER_STATE = 3'd1; CLR_START = 1'b0;
    REQ0 = 1'b0; ADDR0 = '0; DATA0 = '0;
    REQ1 = 1'b0; ADDR1 = '0; DATA1 = '0;
    fork monitor(); join_none

    // Reset for three cycles, then quiet outputs
    repeat (3) @(posedge CLK50);
    #1 RESET = 1'b0;
    mon_en = 1'b1;
    repeat (10) begin
      @(negedge CLK50);
      check("idle_outputs", 64'({GNT0, GNT1, MEM_WE, ADDR_ERR, CLR_DONE, BUSY, MEM_A, MEM_D}), 64'(0));
    end

    // Single write, one-cycle latency, no second grant while REQ0 lingers
    @(posedge CLK50); #1;
    c = cyc;
    push(1, 0, 1, 0, 0, 0, 8'h05, 24'h00FF00, c + 1);
    do_req(1'b0, 8'h05, 24'h00FF00, 20);
    drain("single_write_drained", 20);

    // Contention: strict 0,1,0,1 alternation, a write every cycle
    c = cyc;
    for (int i = 0; i < 4; i++) begin
      push(1, 0, 1, 0, 0, 0, AW'(10 + i), DW'(24'h110000 + i), c + 1 + 2 * i);
      push(0, 1, 1, 0, 0, 0, AW'(20 + i), DW'(24'h220000 + i), c + 2 + 2 * i);
    end
    fork
      begin for (int i = 0; i < 4; i++) do_req(1'b0, AW'(10 + i), DW'(24'h110000 + i), 20); end
      begin for (int j = 0; j < 4; j++) do_req(1'b1, AW'(20 + j), DW'(24'h220000 + j), 20); end
    join
    drain("contention_drained", 20);

    // Sync gating: closed window blocks REQ1 until SER_STATE returns to 1
    SER_STATE = 3'd2;
    fork
      do_req(1'b1, 8'h42, 24'h0000FF, 50);
      begin
        repeat (6) @(posedge CLK50);
        #1;
        push(0, 1, 1, 0, 0, 0, 8'h42, 24'h0000FF, cyc + 1);
        SER_STATE = 3'd1;
      end
    join
    drain("sync_gate_drained", 20);

    // Bulk clear with a stalling window, a re-start pulse, and a request raised mid-clear
    for (int i = 0; i < int'(PIX); i++) push(0, 0, 1, 0, 0, 1, AW'(i), 24'h000000, -1);
    push(0, 0, 0, 0, 1, 0, 8'h00, 24'h000000, -1);
    push(1, 0, 1, 0, 0, 0, 8'h10, 24'hABCDEF, -1);
    stop = 1'b0;
    fork
      begin
        for (int t = 0; t < 60 && !stop; t++) begin
          repeat (50) @(posedge CLK50);
          #1 SER_STATE = (SER_STATE == 3'd1) ? 3'd2 : 3'd1;
        end
        SER_STATE = 3'd1;
      end
      begin
        CLR_START = 1'b1;
        @(posedge CLK50); #1 CLR_START = 1'b0;
        repeat (80) @(posedge CLK50);
        #1 CLR_START = 1'b1;
        @(posedge CLK50); #1 CLR_START = 1'b0;
        @(negedge CLK50);
        check("busy_mid_clear", 64'(BUSY), 64'(1));
        @(posedge CLK50); #1;
        do_req(1'b0, 8'h10, 24'hABCDEF, 2000);
        drain("clear_drained", 500);
        stop = 1'b1;
      end
    join
    @(posedge CLK50); #1;

    // Address range boundaries
    push(1, 0, 0, 1, 0, 0, 8'h00, 24'h000000, -1);
    do_req(1'b0, 8'hFF, 24'h123456, 20);
    push(0, 1, 0, 1, 0, 0, 8'h00, 24'h000000, -1);
    do_req(1'b1, 8'd200, 24'h777777, 20);
    push(0, 1, 1, 0, 0, 0, 8'd199, 24'h654321, -1);
    do_req(1'b1, 8'd199, 24'h654321, 20);
    drain("range_drained", 20);

    // Reset mid-clear right after the write to address 100
    for (int i = 0; i <= 100; i++) push(0, 0, 1, 0, 0, 1, AW'(i), 24'h000000, -1);
    CLR_START = 1'b1;
    @(posedge CLK50); #1 CLR_START = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge CLK50);
      hit = MEM_WE && (MEM_A == 8'd100);
    end
    RESET = 1'b1;
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL abort_point_timeout: got no write to address 100 want one");
    end
    repeat (2) @(posedge CLK50);
    #1 RESET = 1'b0;
    last_a = '0;
    last_d = '0;
    @(negedge CLK50);
    check("abort_busy", 64'(BUSY), 64'(0));
    check("abort_mem_a", 64'(MEM_A), 64'(0));
    check("abort_mem_d", 64'(MEM_D), 64'(0));
    repeat (300) @(negedge CLK50);
    check("abort_sb_empty", 64'(sb_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
